// File: rtl/pwdet_pkg.sv
// Shared types and helpers for the PWM width detector.
//   - pwdet_state_e : per-channel measurement state (IDLE, HIGH, LOW)
//   - STATE_W       : width of the state encoding
//   - cnt_max()     : all-ones value for a count of the given width
//   - sat_inc()     : saturating increment for a count of the given width
// Counts are carried at MAX_CNT_W bits inside the helpers; callers narrow to their CNT_W.
package pwdet_pkg;

   localparam int unsigned STATE_W   = 2;
   localparam int unsigned MAX_CNT_W = 32;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pwdet_state_e;

   function automatic logic [MAX_CNT_W-1:0] cnt_max(input int unsigned cnt_w);
      logic [MAX_CNT_W-1:0] one;
      one = MAX_CNT_W'(1);
      if (cnt_w >= MAX_CNT_W) begin
         return '1;
      end
      return (one << cnt_w) - one;
   endfunction

   function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] cnt,
                                                     input int unsigned          cnt_w);
      logic [MAX_CNT_W-1:0] max_v;
      max_v = cnt_max(cnt_w);
      if (cnt >= max_v) begin
         return max_v;
      end
      return cnt + MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/pwdet_chan.sv
// One channel of the PWM width detector: synchroniser, optional glitch filter, edge detect,
// IDLE/HIGH/LOW measurement FSM, saturating high/low counters and registered outputs.
// Optional feature macro: PWDET_GLITCH_FILTER_EN (level changes only after FILT_LEN stable cycles).
// Ports:
//   sysclk     in   clock, rising edge
//   sysreset   in   synchronous active-high reset
//   pwm_in     in   asynchronous input level
//   clear      in   synchronous channel clear (priority over edges/valid)
//   high_width out  last complete high time in cycles
//   low_width  out  last complete low time in cycles
//   valid      out  one-cycle strobe when widths update
//   ovf        out  sticky: a count saturated since last clear/reset
module pwdet_chan
   import pwdet_pkg::*;
#(
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4
) (
   input  logic             sysclk,
   input  logic             sysreset,
   input  logic             pwm_in,
   input  logic             clear,
   output logic [CNT_W-1:0] high_width,
   output logic [CNT_W-1:0] low_width,
   output logic             valid,
   output logic             ovf
);

   if (SYNC_STAGES < 2 || FILT_LEN < 1 || CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_param
      $error("pwdet_chan: need SYNC_STAGES >= 2, FILT_LEN >= 1, 1 <= CNT_W <= 32");
   end

   localparam logic [MAX_CNT_W-1:0] CntMax = cnt_max(CNT_W);

   // Synchroniser
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Level used for measurement
   logic s;

`ifdef PWDET_GLITCH_FILTER_EN
   localparam int unsigned FCW = $clog2(FILT_LEN + 1);

   logic           filt_q;
   logic [FCW-1:0] fcnt_q;

   // Filtered level follows the synced input only after FILT_LEN consecutive differing cycles,
   // so both edges are delayed by exactly FILT_LEN and widths are preserved.
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else if (sync_out != filt_q) begin
         if (fcnt_q == FCW'(FILT_LEN - 1)) begin
            filt_q <= sync_out;
            fcnt_q <= '0;
         end else begin
            fcnt_q <= fcnt_q + FCW'(1);
         end
      end else begin
         fcnt_q <= '0;
      end
   end

   assign s = filt_q;
`else
   assign s = sync_out;
`endif

   logic s_d_q;
   logic rise;
   logic fall;

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         s_d_q <= 1'b0;
      end else begin
         s_d_q <= s;
      end
   end

   assign rise = s & ~s_d_q;
   assign fall = ~s & s_d_q;

   // Measurement FSM and counters
   pwdet_state_e     state_q, state_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] lcnt_q, lcnt_d;
   logic [CNT_W-1:0] hw_q, hw_d;
   logic [CNT_W-1:0] lw_q, lw_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;

   logic [MAX_CNT_W-1:0] hinc_ext;
   logic [MAX_CNT_W-1:0] linc_ext;
   logic                 hsat;
   logic                 lsat;

   assign hinc_ext = sat_inc(MAX_CNT_W'(hcnt_q), CNT_W);
   assign linc_ext = sat_inc(MAX_CNT_W'(lcnt_q), CNT_W);
   assign hsat     = (hinc_ext == CntMax);
   assign lsat     = (linc_ext == CntMax);

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      lcnt_d  = lcnt_q;
      hw_d    = hw_q;
      lw_d    = lw_q;
      valid_d = 1'b0;
      ovf_d   = ovf_q;

      if (clear) begin
         state_d = IDLE;
         hcnt_d  = '0;
         lcnt_d  = '0;
         hw_d    = '0;
         lw_d    = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d = HIGH;
                  hcnt_d  = CNT_W'(1);
               end
            end
            HIGH: begin
               if (fall) begin
                  state_d = LOW;
                  lcnt_d  = CNT_W'(1);
               end else begin
                  hcnt_d = hinc_ext[CNT_W-1:0];
                  if (hsat) begin
                     ovf_d = 1'b1;
                  end
               end
            end
            LOW: begin
               if (rise) begin
                  // Completed period: publish and start the next high phase
                  hw_d    = hcnt_q;
                  lw_d    = lcnt_q;
                  valid_d = 1'b1;
                  state_d = HIGH;
                  hcnt_d  = CNT_W'(1);
               end else begin
                  lcnt_d = linc_ext[CNT_W-1:0];
                  if (lsat) begin
                     ovf_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         state_q <= IDLE;
         hcnt_q  <= '0;
         lcnt_q  <= '0;
         hw_q    <= '0;
         lw_q    <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         lcnt_q  <= lcnt_d;
         hw_q    <= hw_d;
         lw_q    <= lw_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign high_width = hw_q;
   assign low_width  = lw_q;
   assign valid      = valid_q;
   assign ovf        = ovf_q;

endmodule

// File: rtl/pwm_width_detect.sv
// Multi-channel PWM pulse-width detector. Measures high and low time of each complete period
// per channel in sysclk cycles and reports them with a one-cycle valid strobe.
// Optional feature macro: PWDET_GLITCH_FILTER_EN (per-channel glitch filter, FILT_LEN cycles).
// Ports:
//   sysclk     in   system clock, rising edge
//   sysreset   in   synchronous active-high reset
//   pwm_in     in   NCHAN asynchronous inputs, bit i = channel i
//   clear      in   NCHAN synchronous per-channel clears
//   high_width out  NCHAN*CNT_W, channel i at [i*CNT_W +: CNT_W]
//   low_width  out  NCHAN*CNT_W, same packing
//   valid      out  NCHAN one-cycle update strobes
//   ovf        out  NCHAN sticky saturation flags
module pwm_width_detect
   import pwdet_pkg::*;
#(
   parameter int unsigned NCHAN       = 4,
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_LEN    = 4
) (
   input  logic                   sysclk,
   input  logic                   sysreset,
   input  logic [NCHAN-1:0]       pwm_in,
   input  logic [NCHAN-1:0]       clear,
   output logic [NCHAN*CNT_W-1:0] high_width,
   output logic [NCHAN*CNT_W-1:0] low_width,
   output logic [NCHAN-1:0]       valid,
   output logic [NCHAN-1:0]       ovf
);

   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      pwdet_chan #(
         .CNT_W      (CNT_W),
         .SYNC_STAGES(SYNC_STAGES),
         .FILT_LEN   (FILT_LEN)
      ) u_chan (
         .sysclk    (sysclk),
         .sysreset  (sysreset),
         .pwm_in    (pwm_in[i]),
         .clear     (clear[i]),
         .high_width(high_width[i*CNT_W +: CNT_W]),
         .low_width (low_width[i*CNT_W +: CNT_W]),
         .valid     (valid[i]),
         .ovf       (ovf[i])
      );
   end

endmodule

// File: tb/tb_pwm_width_detect.sv
// Scoreboard bench for pwm_width_detect. Expected (high, low) pairs are queued per channel when
// the completing rise is driven and popped when valid is seen. Channel index 4 is a second,
// single-channel instance built with CNT_W=8 for saturation checks.
module tb_pwm_width_detect;

   localparam int CW    = 24;
   localparam int NCH   = 5;
   localparam int SYNC  = 2;
`ifdef PWDET_GLITCH_FILTER_EN
   localparam int FILT  = 4;
`else
   localparam int FILT  = 0;
`endif
   localparam int LAT   = SYNC + 1 + FILT;
   localparam int P2    = (FILT > 0) ? FILT : 1;

   logic            sysclk = 1'b0;
   logic            sysreset;
   logic [NCH-1:0]  pin;
   logic [3:0]      clr;
   logic            clr8;
   logic [4*CW-1:0] high_width;
   logic [4*CW-1:0] low_width;
   logic [3:0]      valid;
   logic [3:0]      ovf;
   logic [7:0]      hw8;
   logic [7:0]      lw8;
   logic            valid8;
   logic            ovf8;

   always #5 sysclk = ~sysclk;

   pwm_width_detect #(
      .NCHAN      (4),
      .CNT_W      (CW),
      .SYNC_STAGES(SYNC),
      .FILT_LEN   (4)
   ) dut (
      .sysclk    (sysclk),
      .sysreset  (sysreset),
      .pwm_in    (pin[3:0]),
      .clear     (clr),
      .high_width(high_width),
      .low_width (low_width),
      .valid     (valid),
      .ovf       (ovf)
   );

   pwm_width_detect #(
      .NCHAN      (1),
      .CNT_W      (8),
      .SYNC_STAGES(SYNC),
      .FILT_LEN   (4)
   ) dut8 (
      .sysclk    (sysclk),
      .sysreset  (sysreset),
      .pwm_in    (pin[4]),
      .clear     (clr8),
      .high_width(hw8),
      .low_width (lw8),
      .valid     (valid8),
      .ovf       (ovf8)
   );

   typedef struct {
      int h;
      int l;
   } exp_t;

   exp_t expq[NCH][$];
   int   ph[NCH];
   int   pl[NCH];
   bit   have[NCH];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v, input int c);
      int mx;
      mx = (c == 4) ? 255 : ((1 << CW) - 1);
      return (v > mx) ? mx : v;
   endfunction

   // All stimulus tasks are entered and left 1 time unit after a rising edge.
   task automatic do_rise(input int c);
      exp_t e;
      if (have[c]) begin
         e.h = sat(ph[c], c);
         e.l = sat(pl[c], c);
         expq[c].push_back(e);
      end
      pin[c] = 1'b1;
   endtask

   task automatic pulse(input int c, input int h, input int l);
      do_rise(c);
      repeat (h) @(posedge sysclk);
      #1 pin[c] = 1'b0;
      repeat (l) @(posedge sysclk);
      #1;
      ph[c]   = h;
      pl[c]   = l;
      have[c] = 1'b1;
   endtask

   task automatic idle_clear(input string tag);
      repeat (20) @(posedge sysclk);
      #1 clr = '1;
      clr8 = 1'b1;
      @(posedge sysclk);
      #1 clr = '0;
      clr8 = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         have[c] = 1'b0;
         chk($sformatf("%s_pending_ch%0d", tag, c), expq[c].size(), 0);
      end
   endtask

   // Scoreboard monitor
   always @(negedge sysclk) begin
      logic        v;
      logic [31:0] hw;
      logic [31:0] lw;
      exp_t        e;
      for (int c = 0; c < NCH; c++) begin
         if (c < 4) begin
            v  = valid[c];
            hw = 32'(high_width[c*CW +: CW]);
            lw = 32'(low_width[c*CW +: CW]);
         end else begin
            v  = valid8;
            hw = 32'(hw8);
            lw = 32'(lw8);
         end
         if (v) begin
            if (expq[c].size() == 0) begin
               chk($sformatf("spurious_valid_ch%0d", c), 32'(v), 32'd0);
            end else begin
               e = expq[c].pop_front();
               chk($sformatf("ch%0d_high", c), hw, 32'(e.h));
               chk($sformatf("ch%0d_low", c), lw, 32'(e.l));
            end
         end
      end
   end

   initial begin
      sysreset = 1'b1;
      pin      = '0;
      clr      = '0;
      clr8     = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         have[c] = 1'b0;
         ph[c]   = 0;
         pl[c]   = 0;
      end
      repeat (3) @(posedge sysclk);
      #1;
      chk("rst_high", 32'(high_width != '0), 32'd0);
      chk("rst_low", 32'(low_width != '0), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_ovf8", 32'(ovf8), 32'd0);
      sysreset = 1'b0;
      @(posedge sysclk);
      #1;

      // Test 1: ch0 periodic 100/300
      repeat (6) pulse(0, 100, 300);
      chk("t1_ovf", 32'(ovf[0]), 32'd0);
      idle_clear("t1");

      // Test 2: first rise from idle gives no valid; latency after second rise
      pin[0] = 1'b1;
      repeat (LAT) @(posedge sysclk);
      @(negedge sysclk);
      chk("t2_no_valid_first_rise", 32'(valid[0]), 32'd0);
      repeat (20 - LAT) @(posedge sysclk);
      #1 pin[0] = 1'b0;
      repeat (30) @(posedge sysclk);
      #1;
      ph[0] = 20;
      pl[0] = 30;
      have[0] = 1'b1;
      do_rise(0);
      repeat (LAT) @(posedge sysclk);
      @(negedge sysclk);
      chk("t2_latency_valid", 32'(valid[0]), 32'd1);
      @(posedge sysclk);
      #1 chk("t2_valid_one_cycle", 32'(valid[0]), 32'd0);
      repeat (10) @(posedge sysclk);
      #1 pin[0] = 1'b0;
      idle_clear("t2");

      // Test 3: saturation on the CNT_W=8 instance
      pulse(4, 300, 10);
      chk("t3_ovf_set", 32'(ovf8), 32'd1);
      pulse(4, 20, 30);
      pulse(4, 20, 30);
      repeat (LAT + 2) @(posedge sysclk);
      #1 chk("t3_ovf_sticky", 32'(ovf8), 32'd1);
      clr8 = 1'b1;
      @(posedge sysclk);
      #1 clr8 = 1'b0;
      chk("t3_ovf_cleared", 32'(ovf8), 32'd0);
      chk("t3_hw_cleared", 32'(hw8), 32'd0);
      chk("t3_lw_cleared", 32'(lw8), 32'd0);
      have[4] = 1'b0;
      idle_clear("t3");

      // Test 4: clear[0] coincident with the synced fall; ch1 keeps running
      fork
         begin
            pulse(0, 40, 60);
            pulse(0, 40, 60);
            do_rise(0);
            repeat (40) @(posedge sysclk);
            #1 pin[0] = 1'b0;
            repeat (LAT - 1) @(posedge sysclk);
            #1 clr[0] = 1'b1;
            @(posedge sysclk);
            #1 clr[0] = 1'b0;
            have[0] = 1'b0;
            chk("t4_valid_at_clear", 32'(valid[0]), 32'd0);
            chk("t4_hw_cleared", 32'(high_width[0 +: CW]), 32'd0);
            chk("t4_lw_cleared", 32'(low_width[0 +: CW]), 32'd0);
            repeat (30) @(posedge sysclk);
            #1;
            pulse(0, 25, 35);
            pulse(0, 25, 35);
            pulse(0, 25, 35);
         end
         begin
            repeat (8) pulse(1, 30, 30);
         end
      join
      idle_clear("t4");

      // Test 5: concurrent ch1/ch2 with reset while ch1 is mid-measurement
      fork
         repeat (3) pulse(1, 50, 50);
         repeat (60) pulse(2, P2, P2);
      join
      repeat (5) @(posedge sysclk);
      #1;
      chk("t5_ch2_high_pre", 32'(high_width[2*CW +: CW]), 32'(P2));
      chk("t5_ch2_low_pre", 32'(low_width[2*CW +: CW]), 32'(P2));
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("t5_pending_pre_ch%0d", c), expq[c].size(), 0);
         have[c] = 1'b0;
      end
      sysreset = 1'b1;
      @(posedge sysclk);
      #1 sysreset = 1'b0;
      chk("t5_rst_high", 32'(high_width != '0), 32'd0);
      chk("t5_rst_low", 32'(low_width != '0), 32'd0);
      chk("t5_rst_valid", 32'(valid), 32'd0);
      chk("t5_rst_ovf", 32'(ovf), 32'd0);
      fork
         repeat (3) pulse(1, 50, 50);
         repeat (10) pulse(2, P2, P2);
      join
      idle_clear("t5");

      // Test 6: 2-cycle glitch inside a 200-cycle low on ch3
      pulse(3, 30, 100);
`ifdef PWDET_GLITCH_FILTER_EN
      pin[3] = 1'b1;
      repeat (2) @(posedge sysclk);
      #1 pin[3] = 1'b0;
      repeat (98) @(posedge sysclk);
      #1;
      pl[3] = 200;
`else
      pulse(3, 2, 98);
`endif
      pulse(3, 30, 20);
      idle_clear("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
